// File: rtl/adder_rr_sched_if.sv
// Bundle of request, shared-adder and response signals for adder_rr_sched.
// The scheduler takes the slave modport; the requesters, adder and consumer sit on the master side.
interface adder_rr_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*16-1:0] req_a;
    logic [NREQ*16-1:0] req_b;
    logic [NREQ-1:0]    req_cin;
    logic [NREQ-1:0]    req_last;

    logic [15:0]        add_a;
    logic [15:0]        add_b;
    logic               add_cin;
    logic [15:0]        add_sum;
    logic               add_cout;

    logic               resp_valid;
    logic               resp_ready;
    logic [IDW-1:0]     resp_id;
    logic [15:0]        resp_sum;
    logic               resp_cout;
    logic               resp_last;

    logic               busy;

    modport slave (
        input  req_valid, req_a, req_b, req_cin, req_last,
        output req_ready,
        output add_a, add_b, add_cin,
        input  add_sum, add_cout,
        output resp_valid, resp_id, resp_sum, resp_cout, resp_last,
        input  resp_ready,
        output busy
    );

    modport master (
        output req_valid, req_a, req_b, req_cin, req_last,
        input  req_ready,
        input  add_a, add_b, add_cin,
        output add_sum, add_cout,
        input  resp_valid, resp_id, resp_sum, resp_cout, resp_last,
        output resp_ready,
        input  busy
    );
endinterface

// File: rtl/adder_rr_sched.sv
// Round-robin scheduler sharing one external 16-bit adder between NREQ requesters,
// with operand (S1) and result (S2) registers and a held carry for multi-word adds.
module adder_rr_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    adder_rr_sched_if.slave  bus
);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    lock_state_e    lock_q;
    logic [IDW-1:0] lock_id_q;
    logic [IDW-1:0] rr_ptr_q;
    logic [IDW-1:0] rr_ptr_d;
    logic           carry_q;

    logic           s1_valid_q;
    logic [IDW-1:0] s1_id_q;
    logic [15:0]    s1_a_q;
    logic [15:0]    s1_b_q;
    logic           s1_cin_q;
    logic           s1_chain_q;
    logic           s1_last_q;

    logic           s2_valid_q;
    logic [IDW-1:0] s2_id_q;
    logic [15:0]    s2_sum_q;
    logic           s2_cout_q;
    logic           s2_last_q;

    logic           adv;
    logic           locked;
    logic [IDW-1:0] grant;
    logic           grant_vld;
    logic           accept;
    logic [IDW:0]   cand;

    assign adv    = !s2_valid_q | bus.resp_ready;
    assign locked = (lock_q == LOCKED);

    // Scan downward so the last hit is the first valid requester at or after rr_ptr.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        cand      = '0;
        if (locked) begin
            grant     = lock_id_q;
            grant_vld = 1'b1;
        end else begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
                if (cand >= (IDW+1)'(NREQ)) begin
                    cand = cand - (IDW+1)'(NREQ);
                end
                if (bus.req_valid[cand[IDW-1:0]]) begin
                    grant     = cand[IDW-1:0];
                    grant_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_ready[i] = rst_n & adv & grant_vld & (grant == IDW'(i))
                               & (locked | bus.req_valid[i]);
        end
    end

    assign accept   = |(bus.req_ready & bus.req_valid);
    assign rr_ptr_d = (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);

    // Pipeline, lock FSM and inter-word carry share one register block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q     <= UNLOCKED;
            lock_id_q  <= '0;
            rr_ptr_q   <= '0;
            carry_q    <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_cin_q   <= 1'b0;
            s1_chain_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_id_q    <= '0;
            s2_sum_q   <= '0;
            s2_cout_q  <= 1'b0;
            s2_last_q  <= 1'b0;
        end else begin
            if (adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_id_q   <= s1_id_q;
                    s2_sum_q  <= bus.add_sum;
                    s2_cout_q <= bus.add_cout;
                    s2_last_q <= s1_last_q;
                    carry_q   <= bus.add_cout;
                end
                s1_valid_q <= accept;
                if (accept) begin
                    s1_id_q    <= grant;
                    s1_a_q     <= bus.req_a[{grant, 4'b0000} +: 16];
                    s1_b_q     <= bus.req_b[{grant, 4'b0000} +: 16];
                    s1_cin_q   <= bus.req_cin[grant];
                    s1_chain_q <= locked;
                    s1_last_q  <= bus.req_last[grant];
                end
            end
            if (accept) begin
                if (bus.req_last[grant]) begin
                    lock_q   <= UNLOCKED;
                    rr_ptr_q <= rr_ptr_d;
                end else begin
                    lock_q    <= LOCKED;
                    lock_id_q <= grant;
                end
            end
        end
    end

    // A continuation word picks up its carry only when it reaches the adder,
    // by which time the previous word's carry-out has landed in carry_q.
    assign bus.add_a   = s1_a_q;
    assign bus.add_b   = s1_b_q;
    assign bus.add_cin = s1_chain_q ? carry_q : s1_cin_q;

    assign bus.resp_valid = s2_valid_q;
    assign bus.resp_id    = s2_id_q;
    assign bus.resp_sum   = s2_sum_q;
    assign bus.resp_cout  = s2_cout_q;
    assign bus.resp_last  = s2_last_q;

    assign bus.busy = s1_valid_q | s2_valid_q | locked;

endmodule

// File: tb/tb_adder_rr_sched.sv
// Directed bench for adder_rr_sched: a multi-word add model feeds a scoreboard that is
// filled on every request handshake and drained on every response handshake.
module tb_adder_rr_sched;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [15:0]    sum;
        logic           cout;
        logic           last;
    } resp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    adder_rr_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    adder_rr_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {16'b0, bus.add_cin};

    resp_t           expQ[$];
    resp_t           respLog[$];
    int              grantLog[$];
    int              total = 0;
    int              bad = 0;
    int              stallCycles = 0;
    logic [NREQ-1:0] inChain = '0;
    logic [NREQ-1:0] modelCarry = '0;
    bit              chainWatch = 1'b0;
    logic            prevStall = 1'b0;
    logic [20:0]     prevResp = '0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: samples one ns before each rising edge, after inputs and outputs have settled.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                expQ.delete();
                inChain   = '0;
                prevStall = 1'b0;
            end else begin
                resp_t       cur;
                logic [20:0] curFull;
                checkOutput("ready_onehot", 32'($countones(bus.req_ready) <= 1), 32'd1);
                for (int i = 0; i < NREQ; i++) begin
                    if (bus.req_valid[i] && bus.req_ready[i]) begin
                        logic        c;
                        logic [16:0] full;
                        resp_t       e;
                        c    = inChain[i] ? modelCarry[i] : bus.req_cin[i];
                        full = {1'b0, bus.req_a[16*i +: 16]} + {1'b0, bus.req_b[16*i +: 16]} + {16'b0, c};
                        e.id   = IDW'(i);
                        e.sum  = full[15:0];
                        e.cout = full[16];
                        e.last = bus.req_last[i];
                        expQ.push_back(e);
                        modelCarry[i] = full[16];
                        inChain[i]    = !bus.req_last[i];
                        grantLog.push_back(i);
                    end
                end
                if (chainWatch) begin
                    checkOutput("chain_others_ready", 32'(bus.req_ready & 4'b1011), 32'd0);
                end
                cur     = {bus.resp_id, bus.resp_sum, bus.resp_cout, bus.resp_last};
                curFull = {bus.resp_valid, cur};
                if (bus.resp_valid && !bus.resp_ready) begin
                    stallCycles++;
                    checkOutput("stall_no_ready", 32'(bus.req_ready), 32'd0);
                end
                if (prevStall) begin
                    checkOutput("stall_hold", 32'(curFull), 32'(prevResp));
                end
                prevStall = bus.resp_valid & !bus.resp_ready;
                prevResp  = curFull;
                if (bus.resp_valid && bus.resp_ready) begin
                    checkOutput("resp_expected", 32'(expQ.size() > 0), 32'd1);
                    if (expQ.size() > 0) begin
                        checkOutput("resp_data", 32'(cur), 32'(expQ.pop_front()));
                    end
                    respLog.push_back(cur);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int id, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic last);
        bus.req_valid[id]        = 1'b1;
        bus.req_a[16*id +: 16]   = a;
        bus.req_b[16*id +: 16]   = b;
        bus.req_cin[id]          = cin;
        bus.req_last[id]         = last;
    endtask

    task automatic dropReq(input int id);
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic sendWord(input int id, input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input logic last);
        logic got;
        got = 1'b0;
        applyStimulus(id, a, b, cin, last);
        for (int w = 0; w < 40; w++) begin
            #2;
            got = bus.req_ready[id];
            tick();
            if (got) break;
        end
        checkOutput("send_handshake", 32'(got), 32'd1);
    endtask

    task automatic waitIdle();
        for (int w = 0; w < 40; w++) begin
            if (!bus.busy && expQ.size() == 0) break;
            tick();
        end
        checkOutput("drain_idle", {30'b0, bus.busy, expQ.size() != 0}, 32'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        checkOutput({tag, "_add_a"}, 32'(bus.add_a), 32'd0);
        checkOutput({tag, "_add_b"}, 32'(bus.add_b), 32'd0);
        checkOutput({tag, "_add_cin"}, 32'(bus.add_cin), 32'd0);
        checkOutput({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        checkOutput({tag, "_resp_id"}, 32'(bus.resp_id), 32'd0);
        checkOutput({tag, "_resp_sum"}, 32'(bus.resp_sum), 32'd0);
        checkOutput({tag, "_resp_cout"}, 32'(bus.resp_cout), 32'd0);
        checkOutput({tag, "_resp_last"}, 32'(bus.resp_last), 32'd0);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int    fairExp[6];
        int    logStart;
        resp_t chainResp[$];
        resp_t r;

        fairExp = '{0, 1, 2, 3, 0, 1};
        bus.req_valid  = '1;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_cin    = '0;
        bus.req_last   = '1;
        bus.resp_ready = 1'b1;
        rst_n          = 1'b0;
        tick();
        tick();
        checkResetState("reset");
        bus.req_valid = '0;
        rst_n = 1'b1;
        tick();

        $display("[TB] fairness with all requesters valid");
        for (int i = 0; i < NREQ; i++) begin
            applyStimulus(i, 16'h1111 * 16'(i + 1), 16'h0101, 1'(i), 1'b1);
        end
        grantLog.delete();
        for (int w = 0; w < 30; w++) begin
            tick();
            if (grantLog.size() >= 6) break;
        end
        bus.req_valid = '0;
        checkOutput("fair_count", 32'(grantLog.size() >= 6), 32'd1);
        for (int k = 0; k < 6; k++) begin
            if (k < grantLog.size()) begin
                checkOutput($sformatf("fair_grant%0d", k), 32'(grantLog[k]), 32'(fairExp[k]));
            end
        end
        waitIdle();

        $display("[TB] single op latency");
        applyStimulus(0, 16'h1234, 16'h0FF0, 1'b1, 1'b1);
        #2;
        checkOutput("single_ready", 32'(bus.req_ready[0]), 32'd1);
        tick();
        dropReq(0);
        #2;
        checkOutput("single_lat1_valid", 32'(bus.resp_valid), 32'd0);
        tick();
        #2;
        checkOutput("single_lat2_valid", 32'(bus.resp_valid), 32'd1);
        checkOutput("single_sum", 32'(bus.resp_sum), 32'h2225);
        checkOutput("single_cout", 32'(bus.resp_cout), 32'd0);
        checkOutput("single_id", 32'(bus.resp_id), 32'd0);
        checkOutput("single_last", 32'(bus.resp_last), 32'd1);
        tick();
        waitIdle();

        $display("[TB] overflow");
        sendWord(0, 16'hFFFF, 16'h0000, 1'b1, 1'b1);
        dropReq(0);
        waitIdle();
        r = respLog[$];
        checkOutput("ovf_sum", 32'(r.sum), 32'h0000);
        checkOutput("ovf_cout", 32'(r.cout), 32'd1);

        $display("[TB] backpressure on req1 stream");
        logStart    = respLog.size();
        stallCycles = 0;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    sendWord(1, 16'h1000 + 16'h0101 * 16'(k), 16'h0011 * 16'(k), 1'(k), 1'b1);
                end
                dropReq(1);
            end
            begin
                repeat (3) tick();
                bus.resp_ready = 1'b0;
                repeat (5) tick();
                bus.resp_ready = 1'b1;
            end
        join
        waitIdle();
        checkOutput("bp_stall_cycles", 32'(stallCycles), 32'd5);
        checkOutput("bp_resp_count", 32'(respLog.size() - logStart), 32'd6);

        $display("[TB] 48-bit chain from req2 with others waiting");
        logStart = respLog.size();
        applyStimulus(0, 16'h0A0A, 16'h0001, 1'b0, 1'b1);
        applyStimulus(1, 16'h0B0B, 16'h0002, 1'b0, 1'b1);
        applyStimulus(3, 16'h0C0C, 16'h0003, 1'b0, 1'b1);
        chainWatch = 1'b1;
        sendWord(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        sendWord(2, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
        sendWord(2, 16'h0001, 16'h0000, 1'b0, 1'b1);
        chainWatch = 1'b0;
        bus.req_valid = '0;
        waitIdle();
        for (int k = logStart; k < respLog.size(); k++) begin
            if (respLog[k].id == IDW'(2)) chainResp.push_back(respLog[k]);
        end
        checkOutput("chain_count", 32'(chainResp.size()), 32'd3);
        if (chainResp.size() == 3) begin
            checkOutput("chain_w0", 32'({chainResp[0].sum, chainResp[0].cout, chainResp[0].last}), {13'b0, 16'h0000, 1'b1, 1'b0});
            checkOutput("chain_w1", 32'({chainResp[1].sum, chainResp[1].cout, chainResp[1].last}), {13'b0, 16'h0000, 1'b1, 1'b0});
            checkOutput("chain_w2", 32'({chainResp[2].sum, chainResp[2].cout, chainResp[2].last}), {13'b0, 16'h0002, 1'b0, 1'b1});
        end

        $display("[TB] reset in the middle of a req3 chain");
        sendWord(3, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        dropReq(3);
        tick();
        applyStimulus(3, 16'h1234, 16'h0000, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkResetState("midreset");
        applyStimulus(0, 16'h1000, 16'h0001, 1'b0, 1'b1);
        tick();
        tick();
        dropReq(3);
        logStart = respLog.size();
        rst_n = 1'b1;
        #2;
        checkOutput("post_reset_ready", 32'(bus.req_ready), 32'b0001);
        tick();
        dropReq(0);
        waitIdle();
        checkOutput("post_reset_count", 32'(respLog.size() - logStart), 32'd1);
        r = respLog[$];
        checkOutput("post_reset_resp", 32'(r), 32'({2'd0, 16'h1001, 1'b0, 1'b1}));

        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
